// File: rtl/red_tree_pipe.sv
// -----------------------------------------------------------------------------
// red_tree_pipe
//
// Parametrised pipelined reduction tree. NUM_IN scalar inputs are masked,
// then reduced pairwise (AND / OR / XOR, chosen by MODE) over LVL levels.
// Each level is registered. The bus `src` is reduced with the same operator
// in the first level and then carried unchanged through the remaining levels,
// so `dest` leaves the pipe in the same cycle as `out`.
//
// All stages share a valid/ready handshake. While the output is valid and not
// taken, every stage holds, empty slots included. Otherwise every stage moves
// forward by one each cycle.
//
// Parameters:
//   NUM_IN  number of scalar inputs, power of two, 2..64
//   SRC_W   width of the bus input `src`, 1..64
//   MODE    0 = AND, 1 = OR, 2 = XOR
//   LVL     derived: number of tree levels = pipeline latency in cycles
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction valid
//   in_ready   pipeline can accept an input this cycle
//   in_bits    scalar inputs, bit 0 is `a`, bit 1 is `b`, ...
//   in_mask    1 = bit takes part, 0 = bit replaced by the operator identity
//   src        bus reduced alongside the tree
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out        tree result
//   dest       reduction of `src`
//   busy       any pipeline stage holds a valid entry
// -----------------------------------------------------------------------------
module red_tree_pipe #(
    parameter  int NUM_IN = 4,
    parameter  int SRC_W  = 4,
    parameter  int MODE   = 0,
    localparam int LVL    = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] in_bits,
    input  logic [NUM_IN-1:0] in_mask,
    input  logic [SRC_W-1:0]  src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out,
    output logic              dest,
    output logic              busy
);

    // Reject bad parameter sets while the design is elaborated, so that an
    // odd input count or an unknown operator never produces a wrong netlist.
    generate
        if (NUM_IN < 2 || NUM_IN > 64 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
            $error("red_tree_pipe: NUM_IN must be a power of two in 2..64");
        end
        if (MODE < 0 || MODE > 2) begin : g_bad_mode
            $error("red_tree_pipe: MODE must be 0 (AND), 1 (OR) or 2 (XOR)");
        end
        if (SRC_W < 1 || SRC_W > 64) begin : g_bad_src_w
            $error("red_tree_pipe: SRC_W must be in 1..64");
        end
    endgenerate

    // Two-input version of the selected operator, used for every tree node.
    function automatic logic op2(input logic a, input logic b);
        case (MODE)
            0:       op2 = a & b;
            1:       op2 = a | b;
            default: op2 = a ^ b;
        endcase
    endfunction

    // All tree levels are packed into one vector, level 0 at the bottom.
    // Level k holds NUM_IN >> k nodes and starts at this bit offset. The
    // level sizes form a halving series, so the offsets are closed form.
    function automatic int lvl_base(input int k);
        lvl_base = 2 * NUM_IN - ((2 * NUM_IN) >> k);
    endfunction

    // Registered levels 1..LVL, packed in the same order. There are
    // NUM_IN-1 nodes in total, and the last bit is the root.
    logic [NUM_IN-2:0]   node_q;
    logic [NUM_IN-2:0]   node_d;
    logic [NUM_IN-2:0]   node_en;

    // Level 0 (masked inputs) followed by all registered levels.
    logic [2*NUM_IN-2:0] all_nodes;
    logic [NUM_IN-1:0]   masked;

    // Per-stage valid bits and the carried bus reduction.
    logic [LVL:1]        vld_q;
    logic [LVL:1]        dst_q;
    logic [LVL:1]        stage_en;

    logic                src_red;
    logic                stall;
    logic                advance;

    // Handshake. The only combinational input-to-output path runs from
    // out_ready to in_ready.
    assign stall    = vld_q[LVL] & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    // Masked-off bits take the operator identity: 1 for AND, 0 for OR and XOR.
    assign masked    = (MODE == 0) ? (in_bits | ~in_mask) : (in_bits & in_mask);
    assign all_nodes = {node_q, masked};

    // Reduce the whole bus in one go. It joins the pipe at level 1.
    always_comb begin
        src_red = 1'b0;
        case (MODE)
            0:       src_red = &src;
            1:       src_red = |src;
            default: src_red = ^src;
        endcase
    end

    // Next value and load enable for every tree node.
    // A stage loads only when the pipe moves and its upstream neighbour
    // holds a real entry. Data behind a bubble keeps its last value, so the
    // outputs stay deterministic while out_valid is low.
    // Stage 1 loads only on an accepted input. Inputs offered while stalled
    // therefore never reach the data registers.
    always_comb begin
        node_d   = '0;
        node_en  = '0;
        stage_en = '0;
        stage_en[1] = advance & in_valid;
        for (int k = 2; k <= LVL; k++) begin
            stage_en[k] = advance & vld_q[k-1];
        end
        for (int k = 1; k <= LVL; k++) begin
            for (int j = 0; j < (NUM_IN >> k); j++) begin
                node_d[lvl_base(k) - NUM_IN + j] =
                    op2(all_nodes[lvl_base(k-1) + 2*j], all_nodes[lvl_base(k-1) + 2*j + 1]);
                node_en[lvl_base(k) - NUM_IN + j] = stage_en[k];
            end
        end
    end

    // Stage valid shift register. While stalled everything holds, bubbles
    // included. Reset drops every in-flight entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q[1] <= in_valid;
            for (int k = 2; k <= LVL; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Bus reduction carried level by level, alongside the tree data, so it
    // leaves the pipe together with the matching tree result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q <= '0;
        end else begin
            if (stage_en[1]) begin
                dst_q[1] <= src_red;
            end
            for (int k = 2; k <= LVL; k++) begin
                if (stage_en[k]) begin
                    dst_q[k] <= dst_q[k-1];
                end
            end
        end
    end

    // Tree node registers. Each node loads with the enable of its level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_q <= '0;
        end else begin
            for (int i = 0; i < NUM_IN - 1; i++) begin
                if (node_en[i]) begin
                    node_q[i] <= node_d[i];
                end
            end
        end
    end

    assign out_valid = vld_q[LVL];
    assign out       = all_nodes[2*NUM_IN-2];
    assign dest      = dst_q[LVL];
    assign busy      = |vld_q;

endmodule

// File: tb/tb_red_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_red_tree_pipe
//
// Directed testbench for red_tree_pipe. It builds five instances:
//   u0/u1/u2  NUM_IN=4,  SRC_W=4, MODE=0/1/2 (shared inputs)
//   u3        NUM_IN=16, SRC_W=9, MODE=2
//   u4        NUM_IN=2,  SRC_W=1, MODE=1 (single level)
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_red_tree_pipe;

    logic clk;
    logic rst_n;
    logic out_ready;

    logic       in_valid;
    logic [3:0] in_bits;
    logic [3:0] in_mask;
    logic [3:0] src;

    logic in_ready0, out_valid0, out0, dest0, busy0;
    logic in_ready1, out_valid1, out1, dest1, busy1;
    logic in_ready2, out_valid2, out2, dest2, busy2;

    logic        w_valid;
    logic [15:0] w_bits;
    logic [15:0] w_mask;
    logic [8:0]  w_src;
    logic        w_in_ready, w_out_valid, w_out, w_dest, w_busy;

    logic       n_valid;
    logic [1:0] n_bits;
    logic [1:0] n_mask;
    logic [0:0] n_src;
    logic       n_in_ready, n_out_valid, n_out, n_dest, n_busy;

    int checkCount = 0;
    int errorCount = 0;

    // Streaming and backpressure vectors for MODE=0 with expected results.
    logic [3:0] txBits [8];
    logic [3:0] txMask [8];
    logic [3:0] txSrc  [8];
    logic       txOut  [8];
    logic       txDest [8];

    red_tree_pipe #(.NUM_IN(4), .SRC_W(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_bits(in_bits), .in_mask(in_mask), .src(src), .out_valid(out_valid0),
        .out_ready(out_ready), .out(out0), .dest(dest0), .busy(busy0));

    red_tree_pipe #(.NUM_IN(4), .SRC_W(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_bits(in_bits), .in_mask(in_mask), .src(src), .out_valid(out_valid1),
        .out_ready(out_ready), .out(out1), .dest(dest1), .busy(busy1));

    red_tree_pipe #(.NUM_IN(4), .SRC_W(4), .MODE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_bits(in_bits), .in_mask(in_mask), .src(src), .out_valid(out_valid2),
        .out_ready(out_ready), .out(out2), .dest(dest2), .busy(busy2));

    red_tree_pipe #(.NUM_IN(16), .SRC_W(9), .MODE(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_in_ready),
        .in_bits(w_bits), .in_mask(w_mask), .src(w_src), .out_valid(w_out_valid),
        .out_ready(out_ready), .out(w_out), .dest(w_dest), .busy(w_busy));

    red_tree_pipe #(.NUM_IN(2), .SRC_W(1), .MODE(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(n_in_ready),
        .in_bits(n_bits), .in_mask(n_mask), .src(n_src), .out_valid(n_out_valid),
        .out_ready(out_ready), .out(n_out), .dest(n_dest), .busy(n_busy));

    // Free-running clock with a 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive the shared inputs of the three 4-input instances.
    task automatic applyStimulus(input logic v, input logic [3:0] b, input logic [3:0] m, input logic [3:0] s);
        in_valid = v;
        in_bits  = b;
        in_mask  = m;
        src      = s;
    endtask

    // Drive the inputs of the 16-input instance.
    task automatic applyWide(input logic v, input logic [15:0] b, input logic [15:0] m, input logic [8:0] s);
        w_valid = v;
        w_bits  = b;
        w_mask  = m;
        w_src   = s;
    endtask

    // Let one rising edge pass, then settle just after the falling edge.
    // Outputs are sampled there and new inputs are driven there.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        txBits[0] = 4'b1111; txMask[0] = 4'b1111; txSrc[0] = 4'hF; txOut[0] = 1'b1; txDest[0] = 1'b1;
        txBits[1] = 4'b0111; txMask[1] = 4'b1111; txSrc[1] = 4'hF; txOut[1] = 1'b0; txDest[1] = 1'b1;
        txBits[2] = 4'b0111; txMask[2] = 4'b0111; txSrc[2] = 4'hE; txOut[2] = 1'b1; txDest[2] = 1'b0;
        txBits[3] = 4'b0000; txMask[3] = 4'b0000; txSrc[3] = 4'h0; txOut[3] = 1'b1; txDest[3] = 1'b0;
        txBits[4] = 4'b1011; txMask[4] = 4'b1111; txSrc[4] = 4'hF; txOut[4] = 1'b0; txDest[4] = 1'b1;
        txBits[5] = 4'b1000; txMask[5] = 4'b1000; txSrc[5] = 4'h8; txOut[5] = 1'b1; txDest[5] = 1'b0;
        txBits[6] = 4'b1110; txMask[6] = 4'b1110; txSrc[6] = 4'hF; txOut[6] = 1'b1; txDest[6] = 1'b1;
        txBits[7] = 4'b0001; txMask[7] = 4'b1110; txSrc[7] = 4'h3; txOut[7] = 1'b0; txDest[7] = 1'b0;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
        applyWide(1'b0, 16'h0, 16'h0, 9'h0);
        n_valid = 1'b0; n_bits = 2'b00; n_mask = 2'b00; n_src = 1'b0;

        // Reset state.
        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        checkOutput("rst_out",       {31'd0, out0},       32'd0);
        checkOutput("rst_dest",      {31'd0, dest0},      32'd0);
        checkOutput("rst_busy",      {31'd0, busy0},      32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready0},  32'd1);
        rst_n = 1'b1;

        // Basic AND: two transactions, latency of two cycles.
        $display("[TB] basic AND");
        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'hF);
        stepCycle();
        checkOutput("basic_latency", {31'd0, out_valid0}, 32'd0);
        checkOutput("basic_busy",    {31'd0, busy0},      32'd1);
        applyStimulus(1'b1, 4'b1101, 4'b1111, 4'h7);
        stepCycle();
        checkOutput("basic1_valid", {31'd0, out_valid0}, 32'd1);
        checkOutput("basic1_out",   {31'd0, out0},       32'd1);
        checkOutput("basic1_dest",  {31'd0, dest0},      32'd1);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
        stepCycle();
        checkOutput("basic2_valid", {31'd0, out_valid0}, 32'd1);
        checkOutput("basic2_out",   {31'd0, out0},       32'd0);
        checkOutput("basic2_dest",  {31'd0, dest0},      32'd0);
        checkOutput("basic2_or_out",  {31'd0, out1},     32'd1);
        checkOutput("basic2_or_dest", {31'd0, dest1},    32'd1);
        stepCycle();
        checkOutput("basic_drained_valid", {31'd0, out_valid0}, 32'd0);
        checkOutput("basic_drained_busy",  {31'd0, busy0},      32'd0);
        checkOutput("basic_hold_out",      {31'd0, out0},       32'd0);

        // Mask identity for all three operators.
        $display("[TB] mask identity");
        applyStimulus(1'b1, 4'b0011, 4'b0011, 4'h0);
        stepCycle();
        applyStimulus(1'b1, 4'b1010, 4'b0000, 4'h0);
        stepCycle();
        checkOutput("mask_and_out", {31'd0, out0}, 32'd1);
        checkOutput("mask_or_out",  {31'd0, out1}, 32'd1);
        checkOutput("mask_xor_out", {31'd0, out2}, 32'd0);
        checkOutput("mask_and_dest", {31'd0, dest0}, 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
        stepCycle();
        checkOutput("zero_and_out", {31'd0, out0}, 32'd1);
        checkOutput("zero_or_out",  {31'd0, out1}, 32'd0);
        checkOutput("zero_xor_out", {31'd0, out2}, 32'd0);
        checkOutput("zero_valid",   {31'd0, out_valid2}, 32'd1);
        stepCycle();

        // Streaming: eight back-to-back transactions.
        $display("[TB] streaming");
        for (int i = 0; i < 10; i++) begin
            if (i < 8) applyStimulus(1'b1, txBits[i], txMask[i], txSrc[i]);
            else       applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
            stepCycle();
            if (i >= 1 && i <= 8) begin
                checkOutput($sformatf("stream_valid_%0d", i), {31'd0, out_valid0}, 32'd1);
                checkOutput($sformatf("stream_out_%0d", i - 1),  {31'd0, out0},  {31'd0, txOut[i-1]});
                checkOutput($sformatf("stream_dest_%0d", i - 1), {31'd0, dest0}, {31'd0, txDest[i-1]});
            end else begin
                checkOutput($sformatf("stream_valid_%0d", i), {31'd0, out_valid0}, 32'd0);
            end
        end

        // Backpressure: out_ready low for three cycles with a full pipe.
        // Offers made during the stall carry the inverted vector and must
        // be ignored.
        $display("[TB] backpressure");
        begin
            int outIdx;
            int inIdx;
            logic stallNow;
            outIdx = 0;
            inIdx  = 0;
            for (int c = 0; c < 15; c++) begin
                stallNow  = (c >= 2 && c <= 4);
                out_ready = ~stallNow;
                #1;
                if (stallNow) begin
                    checkOutput($sformatf("bp_in_ready_%0d", c),  {31'd0, in_ready0},  32'd0);
                    checkOutput($sformatf("bp_out_valid_%0d", c), {31'd0, out_valid0}, 32'd1);
                end
                if (out_valid0) begin
                    if (outIdx < 8) begin
                        checkOutput($sformatf("bp_out_%0d", outIdx),  {31'd0, out0},  {31'd0, txOut[outIdx]});
                        checkOutput($sformatf("bp_dest_%0d", outIdx), {31'd0, dest0}, {31'd0, txDest[outIdx]});
                    end
                    if (out_ready) outIdx++;
                end
                if (inIdx < 8) begin
                    if (stallNow) begin
                        applyStimulus(1'b1, ~txBits[inIdx], txMask[inIdx], ~txSrc[inIdx]);
                    end else begin
                        applyStimulus(1'b1, txBits[inIdx], txMask[inIdx], txSrc[inIdx]);
                        inIdx++;
                    end
                end else begin
                    applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
                end
                stepCycle();
            end
            checkOutput("bp_count", outIdx, 32'd8);
            checkOutput("bp_idle_busy", {31'd0, busy0}, 32'd0);
        end

        // Reset while two entries are in flight.
        $display("[TB] reset mid-stream");
        out_ready = 1'b1;
        applyStimulus(1'b1, txBits[1], txMask[1], txSrc[1]);
        stepCycle();
        applyStimulus(1'b1, txBits[4], txMask[4], txSrc[4]);
        stepCycle();
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
        out_ready = 1'b0;
        #1;
        checkOutput("mid_pre_in_ready", {31'd0, in_ready0}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_out_valid", {31'd0, out_valid0}, 32'd0);
        checkOutput("mid_busy",      {31'd0, busy0},      32'd0);
        checkOutput("mid_in_ready",  {31'd0, in_ready0},  32'd1);
        checkOutput("mid_dest",      {31'd0, dest0},      32'd0);
        stepCycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'hF);
        stepCycle();
        checkOutput("mid_after_latency", {31'd0, out_valid0}, 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0);
        stepCycle();
        checkOutput("mid_after_valid", {31'd0, out_valid0}, 32'd1);
        checkOutput("mid_after_out",   {31'd0, out0},       32'd1);
        checkOutput("mid_after_dest",  {31'd0, dest0},      32'd1);
        stepCycle();

        // 16-input XOR tree with a 9-bit bus, four levels.
        $display("[TB] wide XOR");
        applyWide(1'b1, 16'h0007, 16'hFFFF, 9'h1FF);
        stepCycle();
        checkOutput("wide_lat1", {31'd0, w_out_valid}, 32'd0);
        applyWide(1'b1, 16'h0003, 16'hFFFF, 9'h0F0);
        stepCycle();
        checkOutput("wide_lat2", {31'd0, w_out_valid}, 32'd0);
        applyWide(1'b0, 16'h0, 16'h0, 9'h0);
        stepCycle();
        checkOutput("wide_lat3", {31'd0, w_out_valid}, 32'd0);
        stepCycle();
        checkOutput("wide1_valid", {31'd0, w_out_valid}, 32'd1);
        checkOutput("wide1_out",   {31'd0, w_out},       32'd1);
        checkOutput("wide1_dest",  {31'd0, w_dest},      32'd1);
        stepCycle();
        checkOutput("wide2_valid", {31'd0, w_out_valid}, 32'd1);
        checkOutput("wide2_out",   {31'd0, w_out},       32'd0);
        checkOutput("wide2_dest",  {31'd0, w_dest},      32'd0);
        stepCycle();
        checkOutput("wide_drained", {31'd0, w_busy}, 32'd0);

        // Two inputs, one level, one-bit bus, OR.
        $display("[TB] single level");
        n_valid = 1'b1; n_bits = 2'b10; n_mask = 2'b01; n_src = 1'b1;
        stepCycle();
        checkOutput("narrow1_valid", {31'd0, n_out_valid}, 32'd1);
        checkOutput("narrow1_out",   {31'd0, n_out},       32'd0);
        checkOutput("narrow1_dest",  {31'd0, n_dest},      32'd1);
        n_valid = 1'b1; n_bits = 2'b10; n_mask = 2'b11; n_src = 1'b0;
        stepCycle();
        checkOutput("narrow2_out",   {31'd0, n_out},       32'd1);
        checkOutput("narrow2_dest",  {31'd0, n_dest},      32'd0);
        n_valid = 1'b0;
        stepCycle();
        checkOutput("narrow_drained", {31'd0, n_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/red_tree_pipe.md
Name: red_tree_pipe

Overview:
- Parametrised successor to the fixed four-input two-level AND gate network with a `src` to `dest` bus path.
- Generalises input count, reduction operator and bus width.
- Registers every tree level into a valid/ready pipeline with backpressure, so `out` and `dest` are cycle-aligned outputs of one transaction.
- Used as a synthesis/parser regression block and as a reusable reduction stage in datapath glue.

Parameters:
- NUM_IN, 4, number of scalar inputs; power of two, 2..64.
- SRC_W, 4, width of bus input `src`; 1..64.
- MODE, 0, reduction operator applied to both the tree and the bus: 0=AND, 1=OR, 2=XOR.
- LVL, $clog2(NUM_IN), derived local parameter; number of tree levels, equal to pipeline latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  pipeline can accept an input this cycle.
- in_bits  input  NUM_IN  scalar inputs; bit 0 is `a`, bit 1 is `b`, and so on.
- in_mask  input  NUM_IN  1 = bit participates; 0 = bit replaced by the operator identity (1 for AND, 0 for OR/XOR).
- src  input  SRC_W  bus reduced alongside the tree.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out  output  1  tree result.
- dest  output  1  reduction of `src`.
- busy  output  1  any pipeline stage holds a valid entry.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids, `out_valid`, `out`, `dest` and `busy` are 0. `in_ready` = 1 as soon as reset is applied. Data registers clear to 0.
- Level k (k=1..LVL) holds NUM_IN/2^k nodes. Node j = op(node 2j, node 2j+1 of level k-1). Level 0 is the masked `in_bits`, combinational.
- The `src` reduction is computed at level 1 and carried unchanged through the remaining levels, so `dest` aligns with `out`.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When not stalled, every stage advances each cycle; stage 1 captures in_valid & in_ready.
  - When stalled, all stages hold, bubbles included (no bubble collapse).
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+LVL-1, i.e. LVL cycles of registering. Throughput is 1 per cycle when out_ready stays high.
- `out`/`dest` stay stable while out_valid=1 and out_ready=0. Values while out_valid=0 are don't-care but must be deterministic (hold last).
- Inputs are sampled only on accept. A change while in_ready=0 has no effect.
- NUM_IN=2 gives a single level, LVL=1.
- SRC_W=1 gives dest = the registered `src`.
- All-mask-zero input gives the identity: AND->1, OR->0, XOR->0.
- Simultaneous accept and output drain on the same edge is legal and loses no data.
- Reset asserted mid-stream discards all in-flight transactions with no partial output. The first accept after release has full latency LVL.
- busy = OR of all stage valids.
- Illegal parameter values (NUM_IN not a power of two, MODE>2) trigger an elaboration-time error.
- No combinational path from in_* to out_*. `in_ready` depends combinationally on `out_ready`, which is the only such path.

Test Plan:
- Reset and basic AND, NUM_IN=4, MODE=0: in_bits=4'b1111, mask=4'b1111, src=4'hF, accepted at cycle 0 -> out_valid=1 with out=1, dest=1 at cycle 2. Next, in_bits=4'b1101 -> out=0; src=4'h7 -> dest=0.
- Mask identity: in_bits=4'b0011, mask=4'b0011 with MODE=0 -> out=1. Mask=4'b0000 -> out=1 for MODE=0, out=0 for MODE=1 and MODE=2.
- Streaming: 8 back-to-back transactions with out_ready=1 -> 8 consecutive out_valid cycles, results in order, starting exactly LVL cycles after the first accept.
- Backpressure: out_ready=0 for 3 cycles with a full pipe:
  - in_ready=0 for those 3 cycles.
  - out/dest held.
  - No transaction lost or duplicated; scoreboard count matches 8/8.
- Reset mid-operation: assert rst_n=0 while 2 entries are in flight -> out_valid=0 and busy=0 immediately. Release, send one entry -> it appears after LVL cycles with the correct value.
- Generalisation, NUM_IN=16, SRC_W=9, MODE=2:
  - in_bits=16'h0007 -> out=1 at LVL=4.
  - src=9'h1FF -> dest=1.
  - src=9'h0F0 -> dest=0.
